// File: rtl/controller_report_bridge.sv
// controller_report_bridge: Avalon-MM gamepad report latched once per VGA frame, optional CTRL_DEBOUNCE_EN per-bit debounce
module controller_report_bridge #(
  parameter int TIMEOUT_FRAMES = 60
`ifdef CTRL_DEBOUNCE_EN
  , parameter int DEBOUNCE_FRAMES = 2
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [1:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       vga_vs,
  output logic [7:0] controller_report,
  output logic [7:0] press_pulse,
  output logic       stale
);
  localparam int IW = $clog2(TIMEOUT_FRAMES + 1);
  logic          vs_q, vs_fall, wr, rd, flush, pending, timeout, apply;
  logic [7:0]    shadow, sticky, fresh, committed, report_next, frame_count;
  logic [IW-1:0] idle_frames, idle_inc;
  assign vs_fall  = vs_q & ~vga_vs;
  assign wr       = chipselect & write;
  assign rd       = chipselect & read;
  assign flush    = wr & (address == 2'd3) & writedata[0];
  assign fresh    = shadow | sticky;
  assign idle_inc = (idle_frames == IW'(TIMEOUT_FRAMES)) ? idle_frames : idle_frames + 1'b1;
  assign timeout  = vs_fall & ~pending & (idle_frames != IW'(TIMEOUT_FRAMES)) & (idle_inc == IW'(TIMEOUT_FRAMES));
`ifdef CTRL_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  logic [7:0]    target, want, flip;
  logic [DW-1:0] db_cnt [8];
  assign want      = pending ? fresh : target;
  assign committed = controller_report ^ flip;
  assign apply     = 1'b1;
  // a bit flips only after enough consecutive commits disagree with it
  always_comb begin
    flip = '0;
    for (int i = 0; i < 8; i++) flip[i] = (want[i] != controller_report[i]) && (int'(db_cnt[i]) + 1 >= DEBOUNCE_FRAMES);
  end
  // per-bit disagreement counters and the last requested report
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      target <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else if (flush || timeout) begin
      target <= '0;
      for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
    end else if (vs_fall) begin
      target <= want;
      for (int i = 0; i < 8; i++) db_cnt[i] <= (want[i] != controller_report[i] && !flip[i]) ? db_cnt[i] + 1'b1 : '0;
    end
`else
  assign committed = fresh;
  assign apply     = pending;
`endif
  assign report_next = timeout ? 8'h00 : apply ? committed : controller_report;
  // frame commit, register writes, watchdog and registered reads
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      vs_q              <= 1'b1;
      shadow            <= '0;
      sticky            <= '0;
      pending           <= 1'b0;
      controller_report <= '0;
      press_pulse       <= '0;
      frame_count       <= '0;
      idle_frames       <= '0;
      stale             <= 1'b0;
      readdata          <= '0;
    end else begin
      vs_q        <= vga_vs;
      press_pulse <= (vs_fall & ~flush) ? report_next & ~controller_report : 8'h00;
      if (vs_fall) frame_count <= frame_count + 8'd1;
      if (vs_fall) controller_report <= report_next;
      if (vs_fall & ~pending) idle_frames <= idle_inc;
      if (vs_fall & pending) begin
        sticky  <= '0;
        pending <= 1'b0;
      end
      if (timeout) stale <= 1'b1;
      if (wr && address == 2'd0) begin
        shadow      <= writedata;
        sticky      <= ((vs_fall & pending) ? 8'h00 : sticky) | writedata;
        pending     <= 1'b1;
        idle_frames <= '0;
        stale       <= 1'b0;
      end
      if (flush) begin
        shadow            <= '0;
        sticky            <= '0;
        pending           <= 1'b0;
        controller_report <= '0;
      end
      if (rd) readdata <= (address == 2'd0) ? shadow :
                          (address == 2'd1) ? controller_report :
                          (address == 2'd2) ? frame_count : {6'b0, stale, pending};
    end
endmodule

// File: tb/tb_controller_report_bridge.sv
// tb_controller_report_bridge: scoreboard bench for controller_report_bridge
module tb_controller_report_bridge;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       chipselect = 1'b0, write = 1'b0, read = 1'b0, vga_vs = 1'b1;
  logic [1:0] address = '0;
  logic [7:0] writedata = '0;
  logic [7:0] readdata, controller_report, press_pulse;
  logic       stale;
  int         checks = 0, errors = 0;
  logic [7:0] fc = '0;
  logic [7:0] q_rep[$], q_pul[$], q_rd[$];

  controller_report_bridge dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .vga_vs(vga_vs),
    .controller_report(controller_report), .press_pulse(press_pulse), .stale(stale)
  );

  always #5 clk = ~clk;

  task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd_reg(input logic [1:0] a, input logic [7:0] exp);
    logic [7:0] e;
    q_rd.push_back(exp);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(posedge clk); #1;
    checks++;
    if (q_rd.size() == 0) begin errors++; $display("FAIL rd_queue_empty addr=%0d", a); end
    else begin
      e = q_rd.pop_front();
      if (readdata !== e) begin errors++; $display("FAIL read addr=%0d got=%h exp=%h", a, readdata, e); end
    end
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  // one VS falling edge, optionally with a register write landing in the same cycle
  task automatic frame(input logic do_wr, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [7:0] er, input logic [7:0] ep);
    logic [7:0] e;
    q_rep.push_back(er);
    q_pul.push_back(ep);
    @(negedge clk);
    vga_vs = 1'b0;
    if (do_wr) begin chipselect = 1'b1; write = 1'b1; address = wa; writedata = wd; end
    @(posedge clk); #1;
    fc++;
    checks += 2;
    e = q_rep.pop_front();
    if (controller_report !== e) begin errors++; $display("FAIL report got=%h exp=%h", controller_report, e); end
    e = q_pul.pop_front();
    if (press_pulse !== e) begin errors++; $display("FAIL pulse got=%h exp=%h", press_pulse, e); end
    @(negedge clk);
    vga_vs = 1'b1; chipselect = 1'b0; write = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (press_pulse !== 8'h00) begin errors++; $display("FAIL pulse_clear got=%h exp=00", press_pulse); end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if ({controller_report, press_pulse, readdata, stale} !== 25'd0) begin
      errors++; $display("FAIL reset_outputs got=%h/%h/%h/%b exp=0", controller_report, press_pulse, readdata, stale);
    end
    reset = 1'b0;
    rd_reg(2'd3, 8'h00);
    rd_reg(2'd2, 8'h00);
    rd_reg(2'd1, 8'h00);
    rd_reg(2'd0, 8'h00);
  endtask

  task automatic test_basic;
    wr_reg(2'd0, 8'h10);
    rd_reg(2'd3, 8'h01);
    frame(1'b0, 2'd0, 8'h00, 8'h10, 8'h10);
    rd_reg(2'd3, 8'h00);
    rd_reg(2'd0, 8'h10);
    rd_reg(2'd1, 8'h10);
  endtask

  task automatic test_sticky;
    wr_reg(2'd0, 8'h01);
    wr_reg(2'd0, 8'h00);
    rd_reg(2'd0, 8'h00);
    frame(1'b0, 2'd0, 8'h00, 8'h01, 8'h01);
    frame(1'b0, 2'd0, 8'h00, 8'h01, 8'h00);
  endtask

  task automatic test_same_cycle;
    wr_reg(2'd0, 8'h02);
    frame(1'b1, 2'd0, 8'h08, 8'h02, 8'h02);
    rd_reg(2'd3, 8'h01);
    frame(1'b0, 2'd0, 8'h00, 8'h08, 8'h08);
  endtask

  task automatic test_watchdog;
    wr_reg(2'd0, 8'h10);
    frame(1'b0, 2'd0, 8'h00, 8'h10, 8'h10);
    for (int i = 1; i <= 60; i++) begin
      frame(1'b0, 2'd0, 8'h00, (i == 60) ? 8'h00 : 8'h10, 8'h00);
      checks++;
      if (stale !== (i == 60)) begin errors++; $display("FAIL stale frame=%0d got=%b exp=%b", i, stale, i == 60); end
    end
    rd_reg(2'd3, 8'h02);
    wr_reg(2'd0, 8'h00);
    checks++;
    if (stale !== 1'b0) begin errors++; $display("FAIL stale_clear got=%b exp=0", stale); end
    rd_reg(2'd3, 8'h01);
    frame(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_flush;
    wr_reg(2'd0, 8'h04);
    frame(1'b0, 2'd0, 8'h00, 8'h04, 8'h04);
    wr_reg(2'd0, 8'h20);
    wr_reg(2'd3, 8'h01);
    rd_reg(2'd3, 8'h00);
    rd_reg(2'd0, 8'h00);
    rd_reg(2'd1, 8'h00);
    frame(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    wr_reg(2'd0, 8'h40);
    frame(1'b1, 2'd3, 8'h01, 8'h00, 8'h00);
    frame(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    wr_reg(2'd1, 8'hFF);
    rd_reg(2'd1, 8'h00);
    wr_reg(2'd2, 8'hFF);
    rd_reg(2'd2, fc);
  endtask

  task automatic test_reset_midframe_wrap;
    wr_reg(2'd0, 8'h80);
    frame(1'b0, 2'd0, 8'h00, 8'h80, 8'h80);
    rd_reg(2'd1, 8'h80);
    @(negedge clk); #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({controller_report, press_pulse, readdata, stale} !== 25'd0) begin
      errors++; $display("FAIL async_reset got=%h/%h/%h/%b exp=0", controller_report, press_pulse, readdata, stale);
    end
    @(negedge clk);
    reset = 1'b0;
    fc = '0;
    repeat (4) @(negedge clk);
    rd_reg(2'd2, 8'h00);
    for (int i = 0; i < 256; i++) frame(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    rd_reg(2'd2, 8'h00);
    rd_reg(2'd3, 8'h02);
    wr_reg(2'd0, 8'h55);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 2'd0;
    #1;
    checks++;
    if (readdata !== 8'h02) begin errors++; $display("FAIL rd_latency_pre got=%h exp=02", readdata); end
    @(posedge clk); #1;
    checks++;
    if (readdata !== 8'h55) begin errors++; $display("FAIL rd_latency_post got=%h exp=55", readdata); end
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    frame(1'b0, 2'd0, 8'h00, 8'h55, 8'h55);
    checks++;
    if (readdata !== 8'h55) begin errors++; $display("FAIL rd_hold got=%h exp=55", readdata); end
    rd_reg(2'd1, 8'h55);
  endtask

  task automatic test_debounce;
    wr_reg(2'd0, 8'h10);
    frame(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
    frame(1'b0, 2'd0, 8'h00, 8'h10, 8'h10);
    frame(1'b0, 2'd0, 8'h00, 8'h10, 8'h00);
    wr_reg(2'd0, 8'h00);
    frame(1'b0, 2'd0, 8'h00, 8'h10, 8'h00);
    frame(1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    test_reset;
`ifdef CTRL_DEBOUNCE_EN
    test_debounce;
`else
    test_basic;
    test_sticky;
    test_same_cycle;
    test_watchdog;
    test_flush;
    test_reset_midframe_wrap;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
